// File: rtl/game_pkg.sv
// Shared encodings for the table-game blocks: FSM states, match results and
// the seven-segment glyph for zero.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    OVER    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    BLUE = 2'b01,
    RED  = 2'b10,
    DRAW = 2'b11
  } winner_e;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

endpackage : game_pkg

// File: rtl/seg7_decoder.sv
// Combinational hex to seven-segment decoder, active-low, bit order gfedcba.
module seg7_decoder (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = '1;
    unique case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = '1;
    endcase
  end

endmodule : seg7_decoder

// File: rtl/score_keeper.sv
// Match controller: start/goal edge detection, score counting, win/draw detection.
// Optional registered score displays when SCORE_SEVENSEG_EN is defined.
module score_keeper
  import game_pkg::*;
#(
  parameter int WIN_SCORE = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       blue_score_up,
  input  logic       red_score_up,
  output logic       game_initiated,
  output logic       game_over,
  output logic [3:0] blue_score,
  output logic [3:0] red_score,
  output logic [1:0] winner
`ifdef SCORE_SEVENSEG_EN
  ,
  output logic [6:0] blue_seg,
  output logic [6:0] red_seg
`endif
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  winner_e    winner_q, winner_d;
  logic [3:0] blue_q, blue_d, red_q, red_d;
  logic       init_q, init_d, over_q, over_d;
  logic       start_prev_q, blue_prev_q, red_prev_q;
  logic       start_edge, blue_ev, red_ev;

  assign start_edge = start_btn & ~start_prev_q;
  assign blue_ev    = blue_score_up ^ blue_prev_q;
  assign red_ev     = red_score_up ^ red_prev_q;

  // Previous-value registers track inputs in every state, reset included,
  // so toggles seen outside PLAYING are consumed rather than deferred.
  always_ff @(posedge clk) begin
    start_prev_q <= start_btn;
    blue_prev_q  <= blue_score_up;
    red_prev_q   <= red_score_up;
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= NONE;
      blue_q   <= '0;
      red_q    <= '0;
      init_q   <= 1'b0;
      over_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      blue_q   <= blue_d;
      red_q    <= red_d;
      init_q   <= init_d;
      over_q   <= over_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    blue_d   = blue_q;
    red_d    = red_q;
    init_d   = 1'b0;
    over_d   = over_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d  = PLAYING;
          winner_d = NONE;
          blue_d   = '0;
          red_d    = '0;
          init_d   = 1'b1;
          over_d   = 1'b0;
        end
      end
      PLAYING: begin
        if (blue_ev && blue_q != WIN) blue_d = blue_q + 4'd1;
        if (red_ev && red_q != WIN)   red_d  = red_q + 4'd1;
        if (blue_d == WIN || red_d == WIN) begin
          state_d = OVER;
          over_d  = 1'b1;
          if (blue_d == WIN && red_d == WIN) winner_d = DRAW;
          else if (blue_d == WIN)            winner_d = BLUE;
          else                               winner_d = RED;
        end
      end
      default: begin
        state_d = IDLE;
        over_d  = 1'b1;
      end
    endcase
  end

  assign game_initiated = init_q;
  assign game_over      = over_q;
  assign blue_score     = blue_q;
  assign red_score      = red_q;
  assign winner         = winner_q;

`ifdef SCORE_SEVENSEG_EN
  logic [6:0] blue_seg_d, red_seg_d, blue_seg_q, red_seg_q;

  seg7_decoder u_blue_dec (.hex_i(blue_q), .seg_o(blue_seg_d));
  seg7_decoder u_red_dec  (.hex_i(red_q),  .seg_o(red_seg_d));

  always_ff @(posedge clk) begin
    if (rst) begin
      blue_seg_q <= SEG_ZERO;
      red_seg_q  <= SEG_ZERO;
    end else begin
      blue_seg_q <= blue_seg_d;
      red_seg_q  <= red_seg_d;
    end
  end

  assign blue_seg = blue_seg_q;
  assign red_seg  = red_seg_q;
`endif

endmodule : score_keeper

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, the goal count that ends a match (range 1..15).
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is on the posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_btn  input  1  start request, active-high, already debounced and synchronous to clk.
REQ-005 SHALL have port blue_score_up  input  1  blue goal event; every level change is one goal.
REQ-006 SHALL have port red_score_up  input  1  red goal event; every level change is one goal.
REQ-007 SHALL have port game_initiated  output  1  one-cycle pulse that launches the ball.
REQ-008 SHALL have port game_over  output  1  level; high holds the ball dead at centre.
REQ-009 SHALL have port blue_score  output  4  blue goal count, unsigned binary.
REQ-010 SHALL have port red_score  output  4  red goal count, unsigned binary.
REQ-011 SHALL have port winner  output  2  match result: 00 none, 01 blue, 10 red, 11 draw.

Function
REQ-012 SHALL implement the FSM states IDLE, PLAYING and OVER.
REQ-013 SHALL take a start edge as the cycle where start_btn=1 and its registered previous value=0; a held button yields exactly one edge.
REQ-014 SHALL on a start edge in IDLE or OVER, at the next clk edge: enter PLAYING, clear both scores to 0, set winner=00, drive game_initiated=1 and game_over=0.
REQ-015 SHALL hold game_initiated high for exactly one cycle per entry to PLAYING and never otherwise.
REQ-016 SHALL drive game_over=1 in IDLE and OVER and 0 in PLAYING, all from registers.
REQ-017 SHALL ignore start edges while in PLAYING.
REQ-018 SHALL detect a goal event as input != its registered previous value; the previous-value registers update every cycle in every state.
REQ-019 SHALL in PLAYING increment the matching score on a goal event, with the new value visible at the next clk edge (1-cycle latency from the sampled toggle).
REQ-020 SHALL ignore goal events in IDLE and OVER; a toggle seen there is never counted later.
REQ-021 SHALL increment both scores in the same cycle when blue and red events coincide.
REQ-022 SHALL saturate each score at WIN_SCORE.
REQ-023 SHALL, in the same clk edge at which a score reaches WIN_SCORE, enter OVER, assert game_over, and set winner to 01 or 10.
REQ-024 SHALL set winner=11 (draw) when both scores reach WIN_SCORE on the same edge.
REQ-025 SHALL hold the scores and winner stable throughout OVER until the next start edge.
REQ-026 SHALL, when a goal event and a start edge coincide in IDLE or OVER, apply the start only (scores=0).

Reset
REQ-027 SHALL, on rst=1 at a clk edge, enter IDLE with blue_score=0, red_score=0, winner=00, game_initiated=0 and game_over=1.
REQ-028 SHALL on reset load the goal and start previous-value registers with the current input levels, so no spurious goal or start is seen after reset.
REQ-029 SHALL, on reset in the middle of PLAYING, abandon the match at once; this is the same behaviour as REQ-027.

Configuration
REQ-030 SHALL, when macro SCORE_SEVENSEG_EN is defined, add outputs blue_seg[6:0] and red_seg[6:0]:
- active-low segment order gfedcba;
- hex digit of each score;
- registered, so they follow the score by 1 cycle.
REQ-031 SHALL, when SCORE_SEVENSEG_EN is undefined, omit those ports and all decode logic; all other behaviour is identical.

Structure
REQ-032 SHALL take from shared package game_pkg the FSM state encodings (IDLE=0, PLAYING=1, OVER=2) and the winner codes (NONE, BLUE, RED, DRAW).
REQ-033 SHALL instantiate sub-module seg7_decoder (4-bit in, 7-bit active-low out, combinational) twice, only under SCORE_SEVENSEG_EN.

Verification
REQ-034 SHALL check reset: hold rst 1 cycle with blue_score_up=1 and red_score_up=0 -> IDLE, game_over=1, scores 0, no goal counted after release.
REQ-035 SHALL check start: hold start_btn high for 10 cycles in IDLE -> exactly one game_initiated pulse, game_over=0 from the same edge.
REQ-036 SHALL check a blue win: in PLAYING with WIN_SCORE=5, toggle blue_score_up 5 times, 20 cycles apart -> blue_score 1..5, OVER on the 5th, winner=01, game_over=1.
REQ-037 SHALL check a draw: at scores 4-4, toggle both inputs in the same cycle -> both 5, winner=11, OVER.
REQ-038 SHALL check ignored goals: toggle red_score_up 3 times in OVER, then give a start edge -> red_score=0 and one game_initiated pulse.
REQ-039 SHALL check mid-match reset: at scores 2-3 in PLAYING, assert rst -> IDLE, scores 0, game_over=1; with SCORE_SEVENSEG_EN, red_seg=7'b1000000 one cycle later.
